// File: rtl/cdec8_cu_pkg.sv
// CDEC8 control unit: control-word field codes, opcodes, state codes and decode helpers.
package cdec8_cu_pkg;

  localparam int unsigned CTRL_W  = 17;
  localparam int unsigned STATE_W = 8;

  // Bus source select
  localparam logic [3:0] XS_PC    = 4'h0;
  localparam logic [3:0] XS_A     = 4'h1;
  localparam logic [3:0] XS_B     = 4'h2;
  localparam logic [3:0] XS_C     = 4'h3;
  localparam logic [3:0] XS_R     = 4'h4;
  localparam logic [3:0] XS_RDR   = 4'h5;
  localparam logic [3:0] XS_FLG   = 4'h6;
  localparam logic [3:0] XS_FF    = 4'h7;
  localparam logic [3:0] XS_IPORT = 4'h8;

  // Bus destination select
  localparam logic [3:0] XD_PC    = 4'h0;
  localparam logic [3:0] XD_A     = 4'h1;
  localparam logic [3:0] XD_B     = 4'h2;
  localparam logic [3:0] XD_C     = 4'h3;
  localparam logic [3:0] XD_MAR   = 4'h4;
  localparam logic [3:0] XD_WDR   = 4'h5;
  localparam logic [3:0] XD_T     = 4'h6;
  localparam logic [3:0] XD_I     = 4'h7;
  localparam logic [3:0] XD_OPORT = 4'h8;
  localparam logic [3:0] XD_NONE  = 4'hF;

  // Memory request
  localparam logic [1:0] MM_IDLE  = 2'b00;
  localparam logic [1:0] MM_WRITE = 2'b01;
  localparam logic [1:0] MM_READ  = 2'b10;

  // ALU operations (second operand is T)
  localparam logic [4:0] ALU_NOP = 5'h00;
  localparam logic [4:0] ALU_ADD = 5'h01;
  localparam logic [4:0] ALU_SUB = 5'h02;
  localparam logic [4:0] ALU_AND = 5'h03;
  localparam logic [4:0] ALU_OR  = 5'h04;
  localparam logic [4:0] ALU_XOR = 5'h05;
  localparam logic [4:0] ALU_INC = 5'h06;
  localparam logic [4:0] ALU_DEC = 5'h07;

  // Opcodes (I[7:4])
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LD  = 4'h1;
  localparam logic [3:0] OP_ST  = 4'h2;
  localparam logic [3:0] OP_LDM = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_SUB = 4'h5;
  localparam logic [3:0] OP_AND = 4'h6;
  localparam logic [3:0] OP_OR  = 4'h7;
  localparam logic [3:0] OP_XOR = 4'h8;
  localparam logic [3:0] OP_INC = 4'h9;
  localparam logic [3:0] OP_DEC = 4'hA;
  localparam logic [3:0] OP_JCC = 4'hB;
  localparam logic [3:0] OP_IN  = 4'hC;
  localparam logic [3:0] OP_OUT = 4'hD;
  localparam logic [3:0] OP_RSV = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // Datapath control word
  typedef struct packed {
    logic [1:0] mmrw;
    logic       fwr;
    logic       rwr;
    logic [3:0] xdst;
    logic [4:0] aluop;
    logic [3:0] xsrc;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = {MM_IDLE, 1'b0, 1'b0, XD_NONE, ALU_NOP, XS_FF};

  // Sequencer states; code is what the debug monitor reads back
  typedef enum logic [STATE_W-1:0] {
    S_F0  = 8'h00, S_F1  = 8'h01, S_F2  = 8'h02, S_F3 = 8'h03,
    S_DSP = 8'h04,
    S_OF0 = 8'h08, S_OF1 = 8'h09, S_OF2 = 8'h0A,
    S_E0  = 8'h10, S_E1  = 8'h11, S_E2  = 8'h12,
    S_JN0 = 8'h18, S_JN1 = 8'h19,
    S_HLT = 8'hFF
  } state_e;

  // Register field as bus source; 11 selects the fetched operand byte
  function automatic logic [3:0] src_sel(input logic [1:0] r);
    case (r)
      2'b00:   return XS_A;
      2'b01:   return XS_B;
      2'b10:   return XS_C;
      default: return XS_RDR;
    endcase
  endfunction

  // Register field as bus destination; 11 is not a register
  function automatic logic [3:0] dst_sel(input logic [1:0] r);
    case (r)
      2'b00:   return XD_A;
      2'b01:   return XD_B;
      2'b10:   return XD_C;
      default: return XD_NONE;
    endcase
  endfunction

  // Branch condition on {S,Z,Cy}; cond[2] inverts (so 100 is never)
  function automatic logic cond_met(input logic [2:0] cond, input logic [2:0] szcy);
    logic hit;
    case (cond[1:0])
      2'b00:   hit = 1'b1;
      2'b01:   hit = szcy[1];
      2'b10:   hit = szcy[0];
      default: hit = szcy[2];
    endcase
    return cond[2] ? ~hit : hit;
  endfunction

  // Operand byte needed: immediate source on LD/ALU ops, address on ST/LDM
  function automatic logic needs_of(input logic [3:0] op, input logic [1:0] rs);
    case (op)
      OP_ST, OP_LDM: return 1'b1;
      OP_LD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: return (rs == 2'b11);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_alu2(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_XOR);
  endfunction

endpackage

// File: rtl/cdec8_cu_if.sv
// Control unit <-> datapath/monitor bundle.
interface cdec8_cu_if;
  import cdec8_cu_pkg::*;

  logic                run;
  logic [7:0]          I;
  logic [2:0]          SZCy;
  ctrl_t               ctrl;
  logic [STATE_W-1:0]  state;
  logic                halted;

  modport slave  (input run, I, SZCy, output ctrl, state, halted);
  modport master (output run, I, SZCy, input ctrl, state, halted);
endinterface

// File: rtl/cdec8_cu_dec.sv
// Pure combinational microcode: (state, I) -> datapath control word.
module cdec8_cu_dec
  import cdec8_cu_pkg::*;
(
  input  state_e     i_state,
  input  logic [7:0] i_instr,
  output ctrl_t      o_ctrl_c
);

  logic [3:0] w_op;
  logic [1:0] w_rd;
  logic [1:0] w_rs;

  assign w_op = i_instr[7:4];
  assign w_rd = i_instr[3:2];
  assign w_rs = i_instr[1:0];

  // Control word per state; everything not named stays idle
  always_comb begin
    o_ctrl_c = CTRL_IDLE;
    case (i_state)
      S_F0, S_OF0: begin
        o_ctrl_c.xsrc = XS_PC;
        o_ctrl_c.xdst = XD_MAR;
      end
      S_F1, S_OF1: begin
        o_ctrl_c.mmrw  = MM_READ;
        o_ctrl_c.xsrc  = XS_PC;
        o_ctrl_c.aluop = ALU_INC;
        o_ctrl_c.rwr   = 1'b1;
      end
      S_F2, S_OF2, S_JN1: begin
        o_ctrl_c.xsrc = XS_R;
        o_ctrl_c.xdst = XD_PC;
      end
      S_F3: begin
        o_ctrl_c.xsrc = XS_RDR;
        o_ctrl_c.xdst = XD_I;
      end
      S_JN0: begin
        o_ctrl_c.xsrc  = XS_PC;
        o_ctrl_c.aluop = ALU_INC;
        o_ctrl_c.rwr   = 1'b1;
      end
      S_E0: begin
        case (w_op)
          OP_LD: begin
            o_ctrl_c.xsrc = src_sel(w_rs);
            o_ctrl_c.xdst = dst_sel(w_rd);
          end
          OP_ST, OP_LDM: begin
            o_ctrl_c.xsrc = XS_RDR;
            o_ctrl_c.xdst = XD_MAR;
          end
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
            o_ctrl_c.xsrc = src_sel(w_rs);
            o_ctrl_c.xdst = XD_T;
          end
          OP_INC, OP_DEC: begin
            o_ctrl_c.xsrc  = src_sel(w_rd);
            o_ctrl_c.aluop = (w_op == OP_INC) ? ALU_INC : ALU_DEC;
            o_ctrl_c.rwr   = 1'b1;
            o_ctrl_c.fwr   = 1'b1;
          end
          OP_JCC: begin
            o_ctrl_c.xsrc = XS_RDR;
            o_ctrl_c.xdst = XD_PC;
          end
          OP_IN: begin
            o_ctrl_c.xsrc = XS_IPORT;
            o_ctrl_c.xdst = dst_sel(w_rd);
          end
          OP_OUT: begin
            o_ctrl_c.xsrc = src_sel(w_rd);
            o_ctrl_c.xdst = XD_OPORT;
          end
          default: ;
        endcase
      end
      S_E1: begin
        case (w_op)
          OP_ST: begin
            o_ctrl_c.xsrc = src_sel(w_rd);
            o_ctrl_c.xdst = XD_WDR;
          end
          OP_LDM: o_ctrl_c.mmrw = MM_READ;
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
            o_ctrl_c.xsrc  = src_sel(w_rd);
            o_ctrl_c.aluop = 5'(w_op - OP_ADD) + ALU_ADD;
            o_ctrl_c.rwr   = 1'b1;
            o_ctrl_c.fwr   = 1'b1;
          end
          OP_INC, OP_DEC: begin
            o_ctrl_c.xsrc = XS_R;
            o_ctrl_c.xdst = dst_sel(w_rd);
          end
          default: ;
        endcase
      end
      S_E2: begin
        case (w_op)
          OP_ST:  o_ctrl_c.mmrw = MM_WRITE;
          OP_LDM: begin
            o_ctrl_c.xsrc = XS_RDR;
            o_ctrl_c.xdst = dst_sel(w_rd);
          end
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
            o_ctrl_c.xsrc = XS_R;
            o_ctrl_c.xdst = dst_sel(w_rd);
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/cdec8_cu.sv
// CDEC8 control unit: state register, next-state sequencing, run/reset gating of ctrl.
module cdec8_cu
  import cdec8_cu_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  cdec8_cu_if.slave   bus
);

  state_e     r_state;
  state_e     w_state_nxt;
  ctrl_t      w_ctrl;
  logic [3:0] w_op;
  logic [1:0] w_rs;

  assign w_op = bus.I[7:4];
  assign w_rs = bus.I[1:0];

  cdec8_cu_dec u_dec (
    .i_state  (r_state),
    .i_instr  (bus.I),
    .o_ctrl_c (w_ctrl)
  );

  // State register; reset returns to fetch immediately
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_F0;
    else       r_state <= w_state_nxt;
  end

  // Next state; run=0 holds, I is valid from the dispatch cycle onwards
  always_comb begin
    w_state_nxt = r_state;
    if (bus.run) begin
      case (r_state)
        S_F0:  w_state_nxt = S_F1;
        S_F1:  w_state_nxt = S_F2;
        S_F2:  w_state_nxt = S_F3;
        S_F3:  w_state_nxt = S_DSP;
        S_DSP: begin
          case (w_op)
            OP_NOP, OP_RSV: w_state_nxt = S_F0;
            OP_HLT:         w_state_nxt = S_HLT;
            OP_JCC:         w_state_nxt = cond_met(bus.I[2:0], bus.SZCy) ? S_OF0 : S_JN0;
            default:        w_state_nxt = needs_of(w_op, w_rs) ? S_OF0 : S_E0;
          endcase
        end
        S_OF0: w_state_nxt = S_OF1;
        S_OF1: w_state_nxt = S_OF2;
        S_OF2: w_state_nxt = S_E0;
        S_E0: begin
          if (w_op == OP_ST || w_op == OP_LDM || is_alu2(w_op) ||
              w_op == OP_INC || w_op == OP_DEC)
            w_state_nxt = S_E1;
          else
            w_state_nxt = S_F0;
        end
        S_E1: begin
          if (w_op == OP_ST || w_op == OP_LDM || is_alu2(w_op))
            w_state_nxt = S_E2;
          else
            w_state_nxt = S_F0;
        end
        S_E2:  w_state_nxt = S_F0;
        S_JN0: w_state_nxt = S_JN1;
        S_JN1: w_state_nxt = S_F0;
        S_HLT: w_state_nxt = S_HLT;
        default: w_state_nxt = S_F0;
      endcase
    end
  end

  // Datapath sees IDLE during reset or pause so no register is written
  assign bus.ctrl   = (reset || !bus.run) ? CTRL_IDLE : w_ctrl;
  assign bus.state  = r_state;
  assign bus.halted = (r_state == S_HLT);

endmodule

// File: tb/tb_cdec8_cu.sv
// Bench: cdec8_cu driving a small datapath + 256x8 memory model; scoreboarded checks.
module tb_cdec8_cu;
  import cdec8_cu_pkg::*;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  cdec8_cu_if bus();

  cdec8_cu dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- datapath + memory model ----------------
  logic [7:0] mem [256];
  logic [7:0] m_pc, m_a, m_b, m_c, m_r, m_rdr, m_wdr, m_t, m_mar, m_i, m_oport;
  logic [2:0] m_flg;
  logic [7:0] iport;
  int         n_fwr, n_rd, n_wr;
  logic       clr_mem, ld_en;
  logic [7:0] ld_addr, ld_data;
  ctrl_t      c;
  logic [7:0] w_bus;
  logic [8:0] w_alu;

  assign c        = bus.ctrl;
  assign bus.I    = m_i;
  assign bus.SZCy = m_flg;
  assign iport    = 8'h3C;

  always_comb begin
    case (c.xsrc)
      XS_PC:    w_bus = m_pc;
      XS_A:     w_bus = m_a;
      XS_B:     w_bus = m_b;
      XS_C:     w_bus = m_c;
      XS_R:     w_bus = m_r;
      XS_RDR:   w_bus = m_rdr;
      XS_FLG:   w_bus = {5'b0, m_flg};
      XS_IPORT: w_bus = iport;
      default:  w_bus = 8'hFF;
    endcase
  end

  always_comb begin
    case (c.aluop)
      ALU_ADD: w_alu = {1'b0, w_bus} + {1'b0, m_t};
      ALU_SUB: w_alu = {1'b0, w_bus} - {1'b0, m_t};
      ALU_AND: w_alu = {1'b0, w_bus & m_t};
      ALU_OR:  w_alu = {1'b0, w_bus | m_t};
      ALU_XOR: w_alu = {1'b0, w_bus ^ m_t};
      ALU_INC: w_alu = {1'b0, w_bus} + 9'd1;
      ALU_DEC: w_alu = {1'b0, w_bus} - 9'd1;
      default: w_alu = {1'b0, w_bus};
    endcase
  end

  always @(posedge clock) begin
    if (reset) begin
      {m_pc, m_a, m_b, m_c, m_r, m_rdr, m_wdr, m_t, m_mar, m_i, m_oport} <= '0;
      m_flg <= 3'b000;
      n_fwr <= 0; n_rd <= 0; n_wr <= 0;
      if (clr_mem) for (int k = 0; k < 256; k++) mem[k] <= 8'h00;
      else if (ld_en) mem[ld_addr] <= ld_data;
    end else begin
      case (c.xdst)
        XD_PC:    m_pc    <= w_bus;
        XD_A:     m_a     <= w_bus;
        XD_B:     m_b     <= w_bus;
        XD_C:     m_c     <= w_bus;
        XD_MAR:   m_mar   <= w_bus;
        XD_WDR:   m_wdr   <= w_bus;
        XD_T:     m_t     <= w_bus;
        XD_I:     m_i     <= w_bus;
        XD_OPORT: m_oport <= w_bus;
        default: ;
      endcase
      if (c.rwr) m_r <= w_alu[7:0];
      if (c.fwr) begin
        m_flg <= {w_alu[7], (w_alu[7:0] == 8'h00), w_alu[8]};
        n_fwr <= n_fwr + 1;
      end
      if (c.mmrw == MM_READ) begin
        m_rdr <= mem[m_mar];
        n_rd  <= n_rd + 1;
      end else if (c.mmrw == MM_WRITE) begin
        mem[m_mar] <= m_wdr;
        n_wr       <= n_wr + 1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef enum {O_A, O_B, O_PC, O_I, O_FLG, O_NFWR, O_NRD, O_NWR, O_M80,
                O_OPORT, O_CTRL, O_STATE, O_HALT} obs_e;
  typedef struct {
    obs_e        o;
    logic [31:0] v;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] observe(input obs_e o);
    case (o)
      O_A:     return 32'(m_a);
      O_B:     return 32'(m_b);
      O_PC:    return 32'(m_pc);
      O_I:     return 32'(m_i);
      O_FLG:   return 32'(m_flg);
      O_NFWR:  return 32'(n_fwr);
      O_NRD:   return 32'(n_rd);
      O_NWR:   return 32'(n_wr);
      O_M80:   return 32'(mem[8'h80]);
      O_OPORT: return 32'(m_oport);
      O_CTRL:  return 32'(bus.ctrl);
      O_STATE: return 32'(bus.state);
      default: return 32'(bus.halted);
    endcase
  endfunction

  task automatic sb_push(input obs_e o, input logic [31:0] v);
    exp_t e;
    e.o = o;
    e.v = v;
    sb.push_back(e);
  endtask

  task automatic sb_drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk_val(e.o.name(), observe(e.o), e.v);
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic new_prog();
    reset = 1'b1;
    bus.run = 1'b1;
    @(negedge clock);
    clr_mem = 1'b1;
    @(negedge clock);
    clr_mem = 1'b0;
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clock);
    ld_en = 1'b0;
  endtask

  task automatic release_reset();
    reset = 1'b0;
    #1;
  endtask

  task automatic run_to_halt(input int budget);
    int k;
    k = 0;
    while (bus.halted !== 1'b1 && k < budget) begin
      @(negedge clock);
      k++;
    end
    if (bus.halted !== 1'b1) chk_val("halt_timeout", 32'(bus.halted), 32'd1);
  endtask

  ctrl_t f_exp [4];

  initial begin
    reset = 1'b1; bus.run = 1'b1;
    clr_mem = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    f_exp[0] = {MM_IDLE, 1'b0, 1'b0, XD_MAR,  ALU_NOP, XS_PC};
    f_exp[1] = {MM_READ, 1'b0, 1'b1, XD_NONE, ALU_INC, XS_PC};
    f_exp[2] = {MM_IDLE, 1'b0, 1'b0, XD_PC,   ALU_NOP, XS_R};
    f_exp[3] = {MM_IDLE, 1'b0, 1'b0, XD_I,    ALU_NOP, XS_RDR};

    // Reset: F0, not halted, ctrl idle even with run=1
    @(negedge clock);
    sb_push(O_STATE, 32'(S_F0)); sb_push(O_HALT, 0); sb_push(O_CTRL, 32'(CTRL_IDLE));
    sb_drain();

    // Fetch sequence then HLT
    new_prog(); poke(8'h00, 8'hF0);
    release_reset();
    for (int k = 0; k < 4; k++) begin
      sb_push(O_CTRL, 32'(f_exp[k]));
      sb_drain();
      @(negedge clock);
    end
    sb_push(O_I, 32'h0F0); sb_push(O_PC, 32'h01); sb_push(O_HALT, 0);
    sb_drain();
    @(negedge clock);
    sb_push(O_HALT, 1); sb_push(O_CTRL, 32'(CTRL_IDLE)); sb_push(O_STATE, 32'(S_HLT));
    sb_drain();

    // LD A,#5 ; HLT
    new_prog(); poke(8'h00, 8'h13); poke(8'h01, 8'h05); poke(8'h02, 8'hF0);
    sb_push(O_A, 32'h05); sb_push(O_PC, 32'h03); sb_push(O_HALT, 1); sb_push(O_CTRL, 32'(CTRL_IDLE));
    release_reset(); run_to_halt(200); sb_drain();

    // LD A,#FF ; LD B,#1 ; ADD A,B ; HLT
    new_prog();
    poke(8'h00, 8'h13); poke(8'h01, 8'hFF); poke(8'h02, 8'h17); poke(8'h03, 8'h01);
    poke(8'h04, 8'h41); poke(8'h05, 8'hF0);
    sb_push(O_A, 32'h00); sb_push(O_B, 32'h01); sb_push(O_FLG, 32'b011); sb_push(O_NFWR, 1);
    release_reset(); run_to_halt(300); sb_drain();

    // Z=1 after ADD: Jcc Z,0x40 taken
    new_prog();
    poke(8'h00, 8'h13); poke(8'h01, 8'hFF); poke(8'h02, 8'h17); poke(8'h03, 8'h01);
    poke(8'h04, 8'h41); poke(8'h05, 8'hB1); poke(8'h06, 8'h40); poke(8'h07, 8'hF0);
    poke(8'h40, 8'hF0);
    sb_push(O_PC, 32'h41); sb_push(O_I, 32'hF0);
    release_reset(); run_to_halt(300); sb_drain();

    // Z=0: Jcc Z not taken, operand skipped without a memory read
    new_prog(); poke(8'h00, 8'hB1); poke(8'h01, 8'h40); poke(8'h02, 8'hF0); poke(8'h40, 8'hF0);
    sb_push(O_PC, 32'h03); sb_push(O_NRD, 2);
    release_reset(); run_to_halt(200); sb_drain();

    // Z=0: Jcc !Z taken
    new_prog(); poke(8'h00, 8'hB5); poke(8'h01, 8'h40); poke(8'h02, 8'hF0); poke(8'h40, 8'hF0);
    sb_push(O_PC, 32'h41); sb_push(O_NRD, 3);
    release_reset(); run_to_halt(200); sb_drain();

    // LD A,#5A ; ST A,[80] ; LDM B,[80] ; HLT
    new_prog();
    poke(8'h00, 8'h13); poke(8'h01, 8'h5A); poke(8'h02, 8'h20); poke(8'h03, 8'h80);
    poke(8'h04, 8'h34); poke(8'h05, 8'h80); poke(8'h06, 8'hF0);
    sb_push(O_M80, 32'h5A); sb_push(O_B, 32'h5A); sb_push(O_NWR, 1);
    release_reset(); run_to_halt(300); sb_drain();

    // IN B ; OUT B ; HLT
    new_prog(); poke(8'h00, 8'hC4); poke(8'h01, 8'hD4); poke(8'h02, 8'hF0);
    sb_push(O_B, 32'h3C); sb_push(O_OPORT, 32'h3C); sb_push(O_NFWR, 0);
    release_reset(); run_to_halt(200); sb_drain();

    // run=0 for 5 clocks in F1: frozen and idle, then completes normally
    new_prog(); poke(8'h00, 8'h13); poke(8'h01, 8'h05); poke(8'h02, 8'hF0);
    release_reset();
    @(negedge clock);
    bus.run = 1'b0;
    #1;
    for (int k = 0; k < 5; k++) begin
      sb_push(O_STATE, 32'(S_F1)); sb_push(O_CTRL, 32'(CTRL_IDLE)); sb_push(O_PC, 0);
      sb_drain();
      @(negedge clock);
    end
    bus.run = 1'b1;
    sb_push(O_A, 32'h05); sb_push(O_PC, 32'h03); sb_push(O_NRD, 3);
    run_to_halt(200); sb_drain();

    // Reset asserted mid-ADD: immediate F0, ctrl idle, earlier writes kept
    new_prog();
    poke(8'h00, 8'h13); poke(8'h01, 8'hFF); poke(8'h02, 8'h17); poke(8'h03, 8'h01);
    poke(8'h04, 8'h41); poke(8'h05, 8'hF0);
    release_reset();
    begin
      int k;
      k = 0;
      while (!(bus.state == 8'(S_E1) && m_i == 8'h41) && k < 200) begin
        @(negedge clock);
        k++;
      end
      chk_val("reach_add_e1", 32'(bus.state), 32'(S_E1));
    end
    reset = 1'b1;
    #1;
    sb_push(O_STATE, 32'(S_F0)); sb_push(O_CTRL, 32'(CTRL_IDLE)); sb_push(O_HALT, 0);
    sb_push(O_A, 32'hFF);
    sb_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
